// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared mode encoding for the T flip-flop bank
package tff_pkg;

  typedef logic [1:0] tff_mode_t;

  localparam tff_mode_t MODE_HOLD   = 2'b00;
  localparam tff_mode_t MODE_TOGGLE = 2'b01;
  localparam tff_mode_t MODE_LOAD   = 2'b10;
  localparam tff_mode_t MODE_COUNT  = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single posedge T/D flip-flop with async active-low reset
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic tin,
  input  logic ld,
  input  logic din,
  input  logic rv,
  output logic q
);

  logic q_d;
  logic q_q;

  // Load wins over toggle; otherwise the bit flips when tin is set
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = din;
    end else if (tin) begin
      q_d = ~q_q;
    end
  end

  // State flop; rst is active low and takes effect without a clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= rv;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_bank.sv
// rtl/tff_bank.sv - parametrised bank of T flip-flops with toggle, load and count modes
module tff_bank
  import tff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               SAT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             toggled
);

  tff_mode_t        mode_e;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] cnt_tgl;
  logic [WIDTH-1:0] tin_vec;
  logic             load;
  logic             tc_w;
  logic [WIDTH-1:0] q_n;
  logic             toggled_d;
  logic             toggled_q;

  assign mode_e = tff_mode_t'(mode);

  // Terminal count: all ones counting up, all zeros counting down
  assign tc_w = (mode_e == MODE_COUNT) & (up ? (&q_w) : ~(|q_w));

  // Synchronous toggle chain: a bit flips when every lower bit is at the carry/borrow level
  always_comb begin
    logic all_lower;
    cnt_tgl   = '0;
    all_lower = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_tgl[i] = all_lower;
      all_lower  = all_lower & (up ? q_w[i] : ~q_w[i]);
    end
  end

  // Per-cell toggle/load controls, gated by en and by saturation at terminal count
  always_comb begin
    tin_vec = '0;
    load    = 1'b0;
    if (en) begin
      case (mode_e)
        MODE_TOGGLE: tin_vec = t;
        MODE_LOAD:   load    = 1'b1;
        MODE_COUNT: begin
          if (!(SAT && tc_w)) begin
            tin_vec = cnt_tgl;
          end
        end
        default: ;
      endcase
    end
  end

  // Next bank value, used only to detect whether any bit will change
  always_comb begin
    q_n       = load ? d : (q_w ^ tin_vec);
    toggled_d = en & (|(q_n ^ q_w));
  end

  // Change-detect pulse, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggled_q <= 1'b0;
    end else begin
      toggled_q <= toggled_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
        .clk (clk),
        .rst (rst),
        .tin (tin_vec[gi]),
        .ld  (load),
        .din (d[gi]),
        .rv  (RST_VAL[gi]),
        .q   (q_w[gi])
      );
    end
  endgenerate

  assign q       = q_w;
  assign qbar    = ~q_w;
  assign tc      = tc_w;
  assign toggled = toggled_q;

endmodule

// File: tb/tb_tff_bank.sv
// tb/tb_tff_bank.sv - randomized and directed checks of tff_bank against a behavioural model
module tb_tff_bank;

  localparam logic [7:0] RV0 = 8'h00;
  localparam logic [7:0] RV1 = 8'h3C;
  localparam logic       RVW = 1'b0;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] t;
  logic [7:0] d;
  logic       up;

  logic [7:0] q0, qb0, q1, qb1;
  logic       tc0, tg0, tc1, tg1;
  logic [0:0] qw, qbw;
  logic       tcw, tgw;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m0, m1;
  logic       mw;
  logic       et0, et1, etw;

  tff_bank #(.WIDTH(8), .RST_VAL(RV0), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d), .up(up),
    .q(q0), .qbar(qb0), .tc(tc0), .toggled(tg0)
  );

  tff_bank #(.WIDTH(8), .RST_VAL(RV1), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d), .up(up),
    .q(q1), .qbar(qb1), .tc(tc1), .toggled(tg1)
  );

  tff_bank #(.WIDTH(1), .RST_VAL(RVW), .SAT(1'b0)) dut_w1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t[0:0]), .d(d[0:0]), .up(up),
    .q(qw), .qbar(qbw), .tc(tcw), .toggled(tgw)
  );

  // Clock starts high so that posedges land on multiples of 10 ns
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference next value for an 8-bit bank, computed with plain arithmetic
  function automatic logic [7:0] nxt8(input logic [7:0] cur, input bit sat);
    int v;
    v = cur;
    if (!en) return cur;
    case (mode)
      2'd1: return cur ^ t;
      2'd2: return d;
      2'd3: begin
        if (up) begin
          if (sat && v == 255) return cur;
          return 8'((v + 1) % 256);
        end else begin
          if (sat && v == 0) return cur;
          return 8'((v + 255) % 256);
        end
      end
      default: return cur;
    endcase
  endfunction

  function automatic logic nxt1(input logic cur);
    if (!en) return cur;
    case (mode)
      2'd1: return cur ^ t[0];
      2'd2: return d[0];
      2'd3: return ~cur;
      default: return cur;
    endcase
  endfunction

  function automatic logic tc8(input logic [7:0] cur);
    return (mode == 2'd3) && (up ? (cur == 8'hFF) : (cur == 8'h00));
  endfunction

  function automatic logic tc1w(input logic cur);
    return (mode == 2'd3) && (up ? (cur == 1'b1) : (cur == 1'b0));
  endfunction

  task automatic verify();
    logic [7:0] inv0, inv1;
    logic       invw;
    inv0 = ~m0;
    inv1 = ~m1;
    invw = ~mw;
    check("q_wrap", q0, m0);
    check("qbar_wrap", qb0, inv0);
    check("tc_wrap", tc0, tc8(m0));
    check("toggled_wrap", tg0, et0);
    check("q_sat", q1, m1);
    check("qbar_sat", qb1, inv1);
    check("tc_sat", tc1, tc8(m1));
    check("toggled_sat", tg1, et1);
    check("q_w1", qw, mw);
    check("qbar_w1", qbw, invw);
    check("tc_w1", tcw, tc1w(mw));
    check("toggled_w1", tgw, etw);
  endtask

  task automatic model_reset();
    m0 = RV0; m1 = RV1; mw = RVW;
    et0 = 1'b0; et1 = 1'b0; etw = 1'b0;
  endtask

  // One clock edge: advance the model from pre-edge state, then compare just after the edge
  task automatic tick();
    logic [7:0] n0, n1;
    logic       nw;
    @(posedge clk);
    if (rst) begin
      n0 = nxt8(m0, 1'b0);
      n1 = nxt8(m1, 1'b1);
      nw = nxt1(mw);
      et0 = en && (n0 != m0);
      et1 = en && (n1 != m1);
      etw = en && (nw != mw);
      m0 = n0; m1 = n1; mw = nw;
    end else begin
      model_reset();
    end
    #1;
    verify();
  endtask

  initial begin
    logic [7:0] hold0, hold1;
    rst  = 1'b0;
    en   = 1'b1;
    mode = 2'd1;
    t    = 8'hFF;
    d    = 8'h00;
    up   = 1'b1;
    model_reset();

    // Reset: values present immediately and held across an edge
    #1;
    verify();
    tick();
    #4;
    rst = 1'b1;
    #1;
    verify();
    mode = 2'd0;

    // TOGGLE from 00 with A5
    mode = 2'd2; d = 8'h00; tick();
    mode = 2'd1; t = 8'hA5; tick();
    check("toggle_first", q0, 8'hA5);
    check("toggle_first_pulse", tg0, 1'b1);
    tick();
    check("toggle_second", q0, 8'h00);
    check("toggle_second_pulse", tg0, 1'b1);

    // LOAD FE then COUNT up with wrap
    mode = 2'd2; d = 8'hFE; tick();
    mode = 2'd3; up = 1'b1; tick();
    check("count_ff", q0, 8'hFF);
    check("count_ff_tc", tc0, 1'b1);
    tick();
    check("count_wrap_00", q0, 8'h00);
    tick();
    check("count_01", q0, 8'h01);

    // COUNT down with saturation from 01
    mode = 2'd2; d = 8'h01; tick();
    mode = 2'd3; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_down_q", q1, 8'h00);
      check("sat_down_tc", tc1, 1'b1);
      check("sat_down_pulse", tg1, (i == 0) ? 32'd1 : 32'd0);
    end

    // Enable gating with random inputs in every mode
    en = 1'b0;
    hold0 = q0;
    hold1 = q1;
    for (int i = 0; i < 10; i++) begin
      mode = 2'(i % 4);
      t = 8'($urandom);
      d = 8'($urandom);
      up = 1'($urandom);
      tick();
      check("en_hold_wrap", q0, hold0);
      check("en_hold_sat", q1, hold1);
      check("en_no_pulse", tg0, 1'b0);
    end
    en = 1'b1;

    // Async reset mid-count at 37
    mode = 2'd2; d = 8'h36; tick();
    mode = 2'd3; up = 1'b1; tick();
    check("count_37", q0, 8'h37);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_wrap", q0, RV0);
    check("async_rst_sat", q1, RV1);
    check("async_rst_pulse", tg0, 1'b0);
    rst = 1'b1;
    tick();
    check("resume_from_rst", q0, 8'(RV0 + 8'd1));

    // WIDTH=1 counting acts as a T flip-flop
    mode = 2'd2; d = 8'h00; tick();
    mode = 2'd3; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("w1_count", qw, 32'((i + 1) % 2));
      check("w1_tc", tcw, 32'((i + 1) % 2));
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en   = (($urandom % 8) != 0);
      mode = 2'($urandom);
      t    = 8'($urandom);
      d    = ($urandom % 4 == 0) ? 8'hFF : 8'($urandom);
      up   = 1'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
